branch_predictor_bht: RTL and testbench

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

---
 rtl/branch_predictor_bht.sv | 94 +++++++++
 tb/tb_branch_predictor_bht.sv | 131 +++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit saturating-counter branch history table with hit/mispredict statistics.
// Define BP_BTB_EN to add per-entry valid/tag/target storage (tagged BTB with allocation on taken miss).
module branch_predictor_bht #(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc_if,
    output logic        predict_taken,
    output logic [7:0]  predict_target,
    input  logic        update,
    input  logic [7:0]  update_pc,
    input  logic        update_taken,
    input  logic [7:0]  update_target,
    input  logic        update_predicted,
    output logic        mispredict,
    output logic [15:0] update_count,
    output logic [15:0] mispredict_count
);
    localparam int N = 2 ** IDX_BITS;

    logic [1:0]          cnt [N];
    logic [IDX_BITS-1:0] idx_if, idx_up;
    logic [1:0]          cnt_up, cnt_next;
    logic                hit_up, wrong;

    assign idx_if = pc_if[IDX_BITS-1:0];
    assign idx_up = update_pc[IDX_BITS-1:0];
    assign cnt_up = cnt[idx_up];
    assign wrong  = update_taken != update_predicted;

`ifdef BP_BTB_EN
    localparam int TW = 8 - IDX_BITS;
    logic            valid  [N];
    logic [TW-1:0]   tag    [N];
    logic [7:0]      target [N];
    logic            hit_if;

    assign hit_if         = valid[idx_if] && tag[idx_if] == pc_if[7:IDX_BITS];
    assign hit_up         = valid[idx_up] && tag[idx_up] == update_pc[7:IDX_BITS];
    assign predict_taken  = hit_if && cnt[idx_if][1];
    assign predict_target = predict_taken ? target[idx_if] : 8'h00;

    // A taken update either refreshes the hit entry's target or allocates over the old occupant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
            end
        end else if (update && update_taken) begin
            valid[idx_up]  <= 1'b1;
            tag[idx_up]    <= update_pc[7:IDX_BITS];
            target[idx_up] <= update_target;
        end
    end
`else
    logic unused_btb;

    assign unused_btb     = ^{pc_if[7:IDX_BITS], update_pc[7:IDX_BITS], update_target};
    assign hit_up         = 1'b1;
    assign predict_taken  = cnt[idx_if][1];
    assign predict_target = 8'h00;
`endif

    // A taken miss allocates at weakly-taken; a not-taken miss is never written.
    always_comb begin
        cnt_next = !hit_up ? 2'b10 :
                   update_taken ? (cnt_up == 2'b11 ? cnt_up : cnt_up + 2'd1) :
                                  (cnt_up == 2'b00 ? cnt_up : cnt_up - 2'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) cnt[i] <= CNT_INIT;
        end else if (update && (hit_up || update_taken)) begin
            cnt[idx_up] <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict       <= 1'b0;
            update_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= update && wrong;
            if (update && update_count != 16'hFFFF) update_count <= update_count + 16'd1;
            if (update && wrong && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed stimulus pushes hand-computed expectations into a queue;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc_if = 8'h13;
    logic        predict_taken;
    logic [7:0]  predict_target;
    logic        update = 1'b0;
    logic [7:0]  update_pc = 8'h00;
    logic        update_taken = 1'b0;
    logic [7:0]  update_target = 8'h00;
    logic        update_predicted = 1'b0;
    logic        mispredict;
    logic [15:0] update_count;
    logic [15:0] mispredict_count;

`ifdef BP_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    typedef struct packed {
        logic        pt;
        logic [7:0]  tg;
        logic        mp;
        logic [15:0] uc;
        logic [15:0] mc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    branch_predictor_bht dut (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update(update), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted(update_predicted),
        .mispredict(mispredict), .update_count(update_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bt(input logic [7:0] x);
        return BTB ? x : 8'h00;
    endfunction

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, field, act, want);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] pc, input logic u, input logic [7:0] upc,
                         input logic tk, input logic [7:0] tg, input logic pr);
        @(posedge clk);
        #1;
        reset = r; pc_if = pc; update = u; update_pc = upc;
        update_taken = tk; update_target = tg; update_predicted = pr;
    endtask

    task automatic expect_vals(input string nm, input logic pt, input logic [7:0] tg, input logic mp,
                               input logic [15:0] uc, input logic [15:0] mc);
        exp_t e;
        e = '{pt: pt, tg: tg, mp: mp, uc: uc, mc: mc};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "predict_taken", 32'(predict_taken), 32'(e.pt));
                chk(nm, "predict_target", 32'(predict_target), 32'(e.tg));
                chk(nm, "mispredict", 32'(mispredict), 32'(e.mp));
                chk(nm, "update_count", 32'(update_count), 32'(e.uc));
                chk(nm, "mispredict_count", 32'(mispredict_count), 32'(e.mc));
            end
        end
    end

    initial begin : stimulus
        drive(1, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("reset", 0, 8'h00, 0, 0, 0);
        drive(0, 8'h13, 1, 8'h13, 1, 8'h40, 0); expect_vals("same_cycle_old", 0, 8'h00, 0, 0, 0);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("alloc", 1, bt(8'h40), 1, 1, 1);
        drive(0, 8'h13, 1, 8'h13, 1, 8'h40, 1); expect_vals("mp_pulse_end", 1, bt(8'h40), 0, 1, 1);
        drive(0, 8'h13, 1, 8'h13, 1, 8'h40, 1); expect_vals("taken_2", 1, bt(8'h40), 0, 2, 1);
        drive(0, 8'h13, 1, 8'h13, 1, 8'h40, 1); expect_vals("taken_3", 1, bt(8'h40), 0, 3, 1);
        drive(0, 8'h13, 1, 8'h13, 0, 8'h00, 1); expect_vals("sat_hi", 1, bt(8'h40), 0, 4, 1);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("nt_once", 1, bt(8'h40), 1, 5, 2);
        drive(0, 8'h13, 1, 8'h13, 0, 8'h00, 1); expect_vals("nt_pre", 1, bt(8'h40), 0, 5, 2);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("nt_twice", 0, 8'h00, 1, 6, 3);
        drive(0, 8'h13, 1, 8'h13, 0, 8'h00, 0); expect_vals("down_1", 0, 8'h00, 0, 6, 3);
        drive(0, 8'h13, 1, 8'h13, 0, 8'h00, 0); expect_vals("down_2", 0, 8'h00, 0, 7, 3);
        drive(0, 8'h13, 1, 8'h13, 1, 8'h40, 0); expect_vals("up_from_0", 0, 8'h00, 0, 8, 3);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("sat_lo", 0, 8'h00, 1, 9, 4);
        drive(0, 8'h13, 1, 8'h23, 1, 8'h50, 0); expect_vals("alias_pre", 0, 8'h00, 0, 9, 4);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("evict_13", !BTB, 8'h00, 1, 10, 5);
        drive(0, 8'h23, 0, 8'h00, 0, 8'h00, 0); expect_vals("alias_23", 1, bt(8'h50), 0, 10, 5);
        drive(0, 8'h23, 1, 8'h33, 0, 8'h00, 0); expect_vals("miss_nt_pre", 1, bt(8'h50), 0, 10, 5);
        drive(0, 8'h23, 0, 8'h00, 0, 8'h00, 0); expect_vals("miss_nt", BTB, bt(8'h50), 0, 11, 5);
        drive(0, 8'h23, 1, 8'h23, 1, 8'h77, 1); expect_vals("tgt_pre", BTB, bt(8'h50), 0, 11, 5);
        drive(0, 8'h23, 0, 8'h00, 0, 8'h00, 0); expect_vals("tgt_upd", 1, bt(8'h77), 0, 12, 5);
        drive(1, 8'h23, 0, 8'h00, 0, 8'h00, 0); expect_vals("reset_clr", 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 65534; i++) drive(0, 8'h13, 1, 8'h05, 0, 8'h00, 1);
        drive(0, 8'h13, 1, 8'h05, 0, 8'h00, 1); expect_vals("preload", 0, 8'h00, 1, 16'hFFFE, 16'hFFFE);
        drive(0, 8'h13, 1, 8'h05, 0, 8'h00, 1); expect_vals("reach_max", 0, 8'h00, 1, 16'hFFFF, 16'hFFFF);
        drive(0, 8'h13, 1, 8'h05, 0, 8'h00, 1); expect_vals("sat_cnt", 0, 8'h00, 1, 16'hFFFF, 16'hFFFF);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("sat_hold", 0, 8'h00, 1, 16'hFFFF, 16'hFFFF);
        drive(1, 8'h13, 1, 8'h13, 1, 8'h40, 0); expect_vals("reset_mid", 0, 8'h00, 0, 0, 0);
        drive(0, 8'h13, 0, 8'h00, 0, 8'h00, 0); expect_vals("post_reset", 0, 8'h00, 0, 0, 0);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
